// File: rtl/mfp_ahb_lite_ram_arbiter.sv
// mfp_ahb_lite_ram_arbiter: shares one AHB-Lite RAM slave between two masters,
// issuing held transfers to the slave one at a time with no slave-side pipelining.
module mfp_ahb_lite_ram_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  M0_HSEL,
   input  logic [ADDR_WIDTH-1:0] M0_HADDR,
   input  logic [2:0]            M0_HSIZE,
   input  logic [1:0]            M0_HTRANS,
   input  logic                  M0_HWRITE,
   input  logic [31:0]           M0_HWDATA,
   output logic [31:0]           M0_HRDATA,
   output logic                  M0_HREADY,
   output logic                  M0_HRESP,
   input  logic                  M1_HSEL,
   input  logic [ADDR_WIDTH-1:0] M1_HADDR,
   input  logic [2:0]            M1_HSIZE,
   input  logic [1:0]            M1_HTRANS,
   input  logic                  M1_HWRITE,
   input  logic [31:0]           M1_HWDATA,
   output logic [31:0]           M1_HRDATA,
   output logic                  M1_HREADY,
   output logic                  M1_HRESP,
   output logic                  S_HSEL,
   output logic [ADDR_WIDTH-1:0] S_HADDR,
   output logic [2:0]            S_HSIZE,
   output logic [1:0]            S_HTRANS,
   output logic                  S_HWRITE,
   output logic [31:0]           S_HWDATA,
   input  logic [31:0]           S_HRDATA,
   input  logic                  S_HREADY,
   input  logic                  S_HRESP
);
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
   state_t                state;
   logic [1:0]            pend, cap, own, done, pend_nx, hready, wr;
   logic                  owner_vld, owner, rr_ptr, win, data_ph;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [2:0]            size [2];
   logic [31:0]           rdata [2];

   assign data_ph = state == ST_DATA;
   assign own     = owner_vld ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign done    = (data_ph && S_HREADY) ? own : 2'b00;
   assign hready  = ~(pend | own) | done;
   assign cap     = {M1_HSEL & M1_HTRANS[1], M0_HSEL & M0_HTRANS[1]} & hready;
   // an owner capturing on its own completion edge keeps its pending flag
   assign pend_nx = (pend & ~done) | cap;
   assign win     = (pend_nx == 2'b10) | (pend_nx == 2'b11 && ROUND_ROBIN && rr_ptr);

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state     <= ST_IDLE;
         pend      <= '0;
         owner_vld <= 1'b0;
         owner     <= 1'b0;
         rr_ptr    <= 1'b0;
         wr        <= '0;
         addr      <= '{default: '0};
         size      <= '{default: '0};
         rdata     <= '{default: '0};
      end else begin
         pend <= pend_nx;
         if (cap[0]) begin
            addr[0] <= M0_HADDR;
            size[0] <= M0_HSIZE;
            wr[0]   <= M0_HWRITE;
         end
         if (cap[1]) begin
            addr[1] <= M1_HADDR;
            size[1] <= M1_HSIZE;
            wr[1]   <= M1_HWRITE;
         end
         if (done[0]) rdata[0] <= S_HRDATA;
         if (done[1]) rdata[1] <= S_HRDATA;
         if ((state == ST_IDLE || done != 2'b00) && pend_nx != 2'b00) begin
            state     <= ST_ADDR;
            owner_vld <= 1'b1;
            owner     <= win;
            rr_ptr    <= ~win;
         end else if (done != 2'b00) begin
            state     <= ST_IDLE;
            owner_vld <= 1'b0;
         end else if (state == ST_ADDR && S_HREADY)
            state <= ST_DATA;
      end

   assign S_HSEL    = state == ST_ADDR;
   assign S_HTRANS  = S_HSEL ? 2'b10 : 2'b00;
   assign S_HADDR   = S_HSEL ? addr[owner] : '0;
   assign S_HSIZE   = S_HSEL ? size[owner] : 3'b000;
   assign S_HWRITE  = S_HSEL & wr[owner];
   assign S_HWDATA  = data_ph ? (owner ? M1_HWDATA : M0_HWDATA) : '0;
   assign M0_HREADY = hready[0];
   assign M1_HREADY = hready[1];
   assign M0_HRDATA = (own[0] && data_ph) ? S_HRDATA : rdata[0];
   assign M1_HRDATA = (own[1] && data_ph) ? S_HRDATA : rdata[1];
   assign M0_HRESP  = own[0] & data_ph & S_HRESP;
   assign M1_HRESP  = own[1] & data_ph & S_HRESP;
endmodule
